// File: rtl/trig_link_pkg.sv
// Shared definitions for the trigger link serializer: default control
// characters, frame geometry, FSM states and a saturating counter helper.
package trig_link_pkg;

  localparam logic [7:0] SOF_CHAR_DEF  = 8'hFB;
  localparam logic [7:0] IDLE_CHAR_DEF = 8'hBC;
  localparam int         FRAME_LEN     = 6;
  localparam logic [1:0] HDR_VALID     = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CHK  = 2'd2,
    GAP  = 2'd3
  } state_t;

  // Error/drop counters stick at all-ones so a flood of bad words stays visible.
  function automatic logic [7:0] satInc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/trig_link_serializer_if.sv
// AXI4-Stream style trigger word channel between the trigger FIFO and the serializer.
interface trig_link_serializer_if;

  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/trig_link_serializer.sv
// Turns accepted trigger words into SOF + 4 data bytes + XOR checksum frames
// on an 8b+K link, padding with idle commas and enforcing a minimum gap.
module trig_link_serializer
  import trig_link_pkg::*;
#(
  parameter logic [7:0] SOF_CHAR  = SOF_CHAR_DEF,
  parameter logic [7:0] IDLE_CHAR = IDLE_CHAR_DEF,
  parameter int         MIN_GAP   = 1
) (
  input  logic                   ifclk,
  input  logic                   rst_i,
  input  logic                   enable_i,
  trig_link_serializer_if.slave  s_trig,
  output logic [7:0]             link_o,
  output logic                   link_k_o,
  output logic [15:0]            frame_count_o,
  output logic [7:0]             hdr_err_count_o,
  output logic [7:0]             drop_count_o
);

  localparam logic [2:0] GAP_RELOAD = 3'(MIN_GAP - 1);

  state_t      r_state;
  logic [31:0] r_word;
  logic [1:0]  r_byteCnt;
  logic [2:0]  r_gapCnt;
  logic        r_ready;
  logic [7:0]  r_link;
  logic        r_linkK;
  logic [15:0] r_frameCount;
  logic [7:0]  r_hdrErrCount;
  logic [7:0]  r_dropCount;

  logic        w_accept;
  logic [7:0]  w_dataByte;
  logic [7:0]  w_checksum;

  assign w_accept   = s_trig.tvalid && r_ready;
  assign w_checksum = r_word[31:24] ^ r_word[23:16] ^ r_word[15:8] ^ r_word[7:0];

  // Most significant byte leaves the link first.
  always_comb begin
    w_dataByte = r_word[7:0];
    case (r_byteCnt)
      2'd3:    w_dataByte = r_word[31:24];
      2'd2:    w_dataByte = r_word[23:16];
      2'd1:    w_dataByte = r_word[15:8];
      default: w_dataByte = r_word[7:0];
    endcase
  end

  always_ff @(posedge ifclk or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= IDLE;
      r_word        <= '0;
      r_byteCnt     <= '0;
      r_gapCnt      <= '0;
      r_ready       <= 1'b0;
      r_link        <= IDLE_CHAR;
      r_linkK       <= 1'b1;
      r_frameCount  <= '0;
      r_hdrErrCount <= '0;
      r_dropCount   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_link  <= IDLE_CHAR;
          r_linkK <= 1'b1;
          r_ready <= 1'b1;
          // Rejected words are still consumed so the upstream FIFO never stalls.
          if (w_accept) begin
            if (!enable_i) begin
              r_dropCount <= satInc8(r_dropCount);
            end else if (s_trig.tdata[31:30] == HDR_VALID) begin
              r_link    <= SOF_CHAR;
              r_word    <= s_trig.tdata;
              r_byteCnt <= 2'd3;
              r_ready   <= 1'b0;
              r_state   <= DATA;
            end else begin
              r_hdrErrCount <= satInc8(r_hdrErrCount);
            end
          end
        end
        DATA: begin
          r_link    <= w_dataByte;
          r_linkK   <= 1'b0;
          r_byteCnt <= r_byteCnt - 2'd1;
          if (r_byteCnt == 2'd0) begin
            r_state <= CHK;
          end
        end
        CHK: begin
          r_link       <= w_checksum;
          r_linkK      <= 1'b0;
          r_gapCnt     <= GAP_RELOAD;
          r_frameCount <= r_frameCount + 16'd1;
          r_state      <= GAP;
        end
        GAP: begin
          r_link  <= IDLE_CHAR;
          r_linkK <= 1'b1;
          if (r_gapCnt == 3'd0) begin
            r_ready <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_gapCnt <= r_gapCnt - 3'd1;
          end
        end
        default: begin
          r_ready <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign s_trig.tready   = r_ready;
  assign link_o          = r_link;
  assign link_k_o        = r_linkK;
  assign frame_count_o   = r_frameCount;
  assign hdr_err_count_o = r_hdrErrCount;
  assign drop_count_o    = r_dropCount;

endmodule

// File: tb/tb_trig_link_serializer.sv
// Drives two serializers (minimum gap 1 and 8) against a queue-based model of
// the expected link character stream, plus directed checks of known frames.
module tb_trig_link_serializer;
  import trig_link_pkg::*;

  localparam int GAP0 = 1;
  localparam int GAP1 = 8;

  logic ifclk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b1;
  bit   bubbles = 1'b0;

  always #5 ifclk = ~ifclk;

  logic [31:0] tdataD[2] = '{default: '0};
  logic        tvalidD[2] = '{default: 1'b0};
  logic [7:0]  linkO[2];
  logic        linkK[2];
  logic        readyO[2];
  logic [15:0] frameCnt[2];
  logic [7:0]  hdrErr[2];
  logic [7:0]  drop[2];

  trig_link_serializer_if bus0();
  trig_link_serializer_if bus1();

  assign bus0.tdata  = tdataD[0];
  assign bus0.tvalid = tvalidD[0];
  assign bus1.tdata  = tdataD[1];
  assign bus1.tvalid = tvalidD[1];
  assign readyO[0]   = bus0.tready;
  assign readyO[1]   = bus1.tready;

  trig_link_serializer #(.MIN_GAP(GAP0)) dut0 (
    .ifclk(ifclk), .rst_i(rst), .enable_i(enable), .s_trig(bus0.slave),
    .link_o(linkO[0]), .link_k_o(linkK[0]), .frame_count_o(frameCnt[0]),
    .hdr_err_count_o(hdrErr[0]), .drop_count_o(drop[0])
  );

  trig_link_serializer #(.MIN_GAP(GAP1)) dut1 (
    .ifclk(ifclk), .rst_i(rst), .enable_i(enable), .s_trig(bus1.slave),
    .link_o(linkO[1]), .link_k_o(linkK[1]), .frame_count_o(frameCnt[1]),
    .hdr_err_count_o(hdrErr[1]), .drop_count_o(drop[1])
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: each accepted good word appends its whole character
  // sequence (frame + mandatory idles) to a queue; the link drains one per edge
  // and the port is ready again once nothing is left to send.
  logic [31:0] srcQ[2][$];
  logic [9:0]  expQ[2][$];
  bit          mReady[2] = '{default: 1'b0};
  logic [7:0]  mLink[2] = '{default: IDLE_CHAR_DEF};
  logic        mK[2] = '{default: 1'b1};
  logic [15:0] mFrames[2] = '{default: '0};
  logic [7:0]  mHdr[2] = '{default: '0};
  logic [7:0]  mDrop[2] = '{default: '0};
  logic [31:0] mWord;
  logic [9:0]  mItem;

  always @(posedge ifclk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        expQ[d].delete();
        mReady[d] = 1'b0;
        mLink[d] = IDLE_CHAR_DEF;
        mK[d] = 1'b1;
        mFrames[d] = '0;
        mHdr[d] = '0;
        mDrop[d] = '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (mReady[d] && tvalidD[d]) begin
          mWord = tdataD[d];
          if (srcQ[d].size() > 0) void'(srcQ[d].pop_front());
          if (!enable) begin
            mDrop[d] = (mDrop[d] == 8'd255) ? 8'd255 : mDrop[d] + 8'd1;
          end else if (mWord[31:30] == 2'b10) begin
            expQ[d].push_back({2'b01, SOF_CHAR_DEF});
            for (int b = 3; b >= 0; b--) expQ[d].push_back({2'b00, mWord[8*b +: 8]});
            expQ[d].push_back({2'b10, mWord[31:24] ^ mWord[23:16] ^ mWord[15:8] ^ mWord[7:0]});
            for (int g = 0; g < ((d == 0) ? GAP0 : GAP1); g++) expQ[d].push_back({2'b01, IDLE_CHAR_DEF});
          end else begin
            mHdr[d] = (mHdr[d] == 8'd255) ? 8'd255 : mHdr[d] + 8'd1;
          end
        end
        if (expQ[d].size() > 0) begin
          mItem = expQ[d].pop_front();
          mLink[d] = mItem[7:0];
          mK[d] = mItem[8];
          if (mItem[9]) mFrames[d] = mFrames[d] + 16'd1;
        end else begin
          mLink[d] = IDLE_CHAR_DEF;
          mK[d] = 1'b1;
        end
        mReady[d] = (expQ[d].size() == 0);
      end
    end
  end

  // Source side: present the head of each word queue, optionally with bubbles.
  always @(negedge ifclk) begin
    for (int d = 0; d < 2; d++) begin
      if (srcQ[d].size() > 0 && (!bubbles || $urandom_range(0, 3) != 0)) begin
        tvalidD[d] = 1'b1;
        tdataD[d] = srcQ[d][0];
      end else begin
        tvalidD[d] = 1'b0;
        tdataD[d] = $urandom;
      end
    end
  end

  always @(negedge ifclk) begin
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("link%0d", d), {24'd0, linkO[d]}, {24'd0, mLink[d]});
      checkOutput($sformatf("k%0d", d), {31'd0, linkK[d]}, {31'd0, mK[d]});
      checkOutput($sformatf("ready%0d", d), {31'd0, readyO[d]}, {31'd0, mReady[d]});
      checkOutput($sformatf("frames%0d", d), {16'd0, frameCnt[d]}, {16'd0, mFrames[d]});
      checkOutput($sformatf("hdrErr%0d", d), {24'd0, hdrErr[d]}, {24'd0, mHdr[d]});
      checkOutput($sformatf("drop%0d", d), {24'd0, drop[d]}, {24'd0, mDrop[d]});
    end
  end

  task automatic applyStimulus(input int d, input logic [31:0] word);
    srcQ[d].push_back(word);
  endtask

  task automatic waitDrained();
    bit done = 1'b0;
    for (int c = 0; c < 5000 && !done; c++) begin
      @(negedge ifclk);
      done = (srcQ[0].size() == 0) && (srcQ[1].size() == 0) && mReady[0] && mReady[1];
    end
    if (!done) checkOutput("drainTimeout", 32'd0, 32'd1);
  endtask

  task automatic waitSof(input int d);
    bit seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge ifclk);
      seen = (linkO[d] == SOF_CHAR_DEF) && linkK[d];
    end
    if (!seen) checkOutput("sofTimeout", 32'd0, 32'd1);
  endtask

  logic [7:0] knownBytes[5] = '{8'h8A, 8'hBC, 8'h00, 8'h12, 8'h24};

  initial begin
    repeat (3) @(negedge ifclk);
    checkOutput("rstReady", {31'd0, readyO[0]}, 32'd0);
    checkOutput("rstLink", {24'd0, linkO[0]}, 32'hBC);
    checkOutput("rstK", {31'd0, linkK[0]}, 32'd1);
    rst = 1'b0;
    @(negedge ifclk);
    checkOutput("readyAfterRst", {31'd0, readyO[0]}, 32'd1);

    // Known frame with a hand-computed checksum.
    #2 applyStimulus(0, 32'h8ABC0012);
    waitSof(0);
    for (int i = 0; i < 5; i++) begin
      @(negedge ifclk);
      checkOutput($sformatf("knownByte%0d", i), {23'd0, linkK[0], linkO[0]}, {24'd0, knownBytes[i]});
    end
    @(negedge ifclk);
    checkOutput("knownIdle", {23'd0, linkK[0], linkO[0]}, 32'h1BC);
    checkOutput("knownFrames", {16'd0, frameCnt[0]}, 32'd1);
    waitDrained();

    // Bad header: consumed, counted, port ready again immediately.
    #2 applyStimulus(0, 32'h40000001);
    @(negedge ifclk);
    @(negedge ifclk);
    checkOutput("hdrReady", {31'd0, readyO[0]}, 32'd1);
    checkOutput("hdrCount1", {24'd0, hdrErr[0]}, 32'd1);
    for (int i = 0; i < 300; i++) applyStimulus(0, 32'h40000001);
    waitDrained();
    checkOutput("hdrSat", {24'd0, hdrErr[0]}, 32'd255);

    // Disabled words are dropped without a frame.
    enable = 1'b0;
    applyStimulus(0, 32'h8ABC0012);
    applyStimulus(0, 32'h81230045);
    waitDrained();
    checkOutput("dropCount", {24'd0, drop[0]}, 32'd2);
    checkOutput("dropFrames", {16'd0, frameCnt[0]}, 32'd1);
    enable = 1'b1;

    // Enable falling mid-frame must not truncate the frame.
    #2 applyStimulus(0, 32'h9F00_00A5);
    waitSof(0);
    enable = 1'b0;
    waitDrained();
    checkOutput("midDisableFrames", {16'd0, frameCnt[0]}, 32'd2);
    enable = 1'b1;

    // Back-to-back valid words on both gap settings.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 32'h80000000 | (i << 8) | 32'h5A);
      applyStimulus(1, 32'hB0000000 | (i << 8) | 32'hC3);
    end
    waitDrained();
    checkOutput("b2bFrames1", {16'd0, frameCnt[1]}, 32'd3);

    // Frame counter wrap from 0xFFFF.
    @(negedge ifclk);
    #2 force dut0.r_frameCount = 16'hFFFF;
    mFrames[0] = 16'hFFFF;
    @(negedge ifclk);
    #2 release dut0.r_frameCount;
    applyStimulus(0, 32'h80000001);
    waitDrained();
    checkOutput("frameWrap", {16'd0, frameCnt[0]}, 32'd0);

    // Asynchronous reset in the middle of the second data byte.
    #2 applyStimulus(0, 32'h8ABC0012);
    waitSof(0);
    @(negedge ifclk);
    @(negedge ifclk);
    #2 rst = 1'b1;
    #1;
    checkOutput("asyncRstLink", {23'd0, linkK[0], linkO[0]}, 32'h1BC);
    checkOutput("asyncRstReady", {31'd0, readyO[0]}, 32'd0);
    repeat (2) @(negedge ifclk);
    rst = 1'b0;
    @(negedge ifclk);
    #2 applyStimulus(0, 32'h8ABC0012);
    waitDrained();
    checkOutput("postRstFrames", {16'd0, frameCnt[0]}, 32'd1);
    checkOutput("postRstHdr", {24'd0, hdrErr[0]}, 32'd0);

    // Randomized traffic with bubbles and occasional disable windows.
    bubbles = 1'b1;
    for (int i = 0; i < 200; i++) begin
      logic [1:0] hdr;
      hdr = ($urandom_range(0, 9) < 7) ? 2'b10 : 2'($urandom);
      applyStimulus(0, {hdr, 12'($urandom), 2'b00, 8'h00, 8'($urandom)});
      applyStimulus(1, {hdr, 12'($urandom), 2'b00, 8'h00, 8'($urandom)});
    end
    for (int c = 0; c < 6000 && (srcQ[0].size() > 0 || srcQ[1].size() > 0); c++) begin
      @(negedge ifclk);
      if (c % 5 == 0) enable = ($urandom_range(0, 9) != 0);
    end
    enable = 1'b1;
    waitDrained();
    bubbles = 1'b0;

    repeat (2) @(negedge ifclk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/trig_link_serializer.md
TRIG_LINK_SERIALIZER -- requirements
Module: trig_link_serializer

Interface
REQ-001 Parameter SOF_CHAR, default 8'hFB: start-of-frame control character.
REQ-002 Parameter IDLE_CHAR, default 8'hBC: idle/comma control character.
REQ-003 Parameter MIN_GAP, default 1, legal range 1..8: idle characters forced after every frame.
REQ-004 Port ifclk, input, 1: the single clock; all logic on its rising edge.
REQ-005 Port rst_i, input, 1: reset, asynchronous and active-high.
REQ-006 Port enable_i, input, 1: run enable; when low, incoming words are discarded.
REQ-007 Port s_trig_tdata, input, 32: trigger word from the trigger generator FIFO, laid out {hdr[1:0], addr[11:0], 2'b00, 8'h00, meta[7:0]}.
REQ-008 Port s_trig_tvalid, input, 1: AXI4-Stream valid.
REQ-009 Port s_trig_tready, output, 1: AXI4-Stream ready, registered.
REQ-010 Port link_o, output, 8: serial link byte, registered.
REQ-011 Port link_k_o, output, 1: link_o carries a control character, registered.
REQ-012 Port frame_count_o, output, 16: frames sent, wrapping.
REQ-013 Port hdr_err_count_o, output, 8: header-error words, saturating.
REQ-014 Port drop_count_o, output, 8: words discarded while disabled, saturating.

Function
REQ-015 FSM states are IDLE, DATA, CHK and GAP; s_trig_tready SHALL be 1 exactly when state == IDLE.
REQ-016 Acceptance is tvalid && tready on a rising edge; no other input word is ever consumed.
REQ-017 Header check: a word is valid iff tdata[31:30] == 2'b10.
REQ-018 Accepted, enable_i=1, valid header: on the acceptance edge link_o<=SOF_CHAR, link_k_o<=1, the word is latched, state<=DATA, byte counter<=3.
REQ-019 DATA: each edge outputs latched byte[cnt] (byte 3 = tdata[31:24] first) with k=0 and decrements cnt; after byte 0 is output, state<=CHK.
REQ-020 CHK: output XOR of the four data bytes, k=0; state<=GAP, gap counter<=MIN_GAP-1.
REQ-021 GAP: output IDLE_CHAR, k=1; when gap counter == 0, state<=IDLE, else decrement.
REQ-022 IDLE: output IDLE_CHAR, k=1 every cycle.
REQ-023 A frame is 6 consecutive link characters (SOF, 4 data, checksum), starting the cycle after acceptance; the minimum acceptance-to-acceptance spacing is 6+MIN_GAP cycles (7 at default).
REQ-024 Accepted with an invalid header (enable_i=1): the word is consumed, no frame is sent, hdr_err_count_o increments (saturating at 255), and state stays IDLE.
REQ-025 Accepted with enable_i=0: the word is consumed, no frame is sent, drop_count_o increments (saturating at 255), and state stays IDLE; the header is not checked.
REQ-026 enable_i falling mid-frame: the current frame and gap complete unchanged.
REQ-027 frame_count_o increments on the edge that outputs the checksum and wraps 0xFFFF->0x0000.
REQ-028 tvalid asserted while the FSM is not in IDLE: no acceptance; tdata is never sampled outside acceptance.

Reset
REQ-029 While rst_i is high (asynchronously): state=IDLE, s_trig_tready=0, link_o=IDLE_CHAR, link_k_o=1, and all counters are 0.
REQ-030 s_trig_tready rises on the first edge after rst_i falls.
REQ-031 Reset mid-frame aborts the frame immediately; no partial frame resumes afterwards.

Structure
REQ-032 Package trig_link_pkg holds the default SOF/IDLE characters, the FSM state enum and the frame length constant (6).
REQ-033 No sub-module: the checksum is inline, and the saturating counters are a package function or inline logic.

Verification
REQ-034 Send word 0x8ABC0012 with enable_i=1 -> link_o FB(k) 8A BC 00 12 24, then BC(k); frame_count_o=1.
REQ-035 Send word 0x40000001 -> no SOF, link stays BC(k), hdr_err_count_o=1, tready high the next cycle; 300 such words -> count holds at 255.
REQ-036 Hold tvalid high with 3 valid words, MIN_GAP=1 -> accepts 7 cycles apart, exactly one BC(k) between frames; MIN_GAP=8 -> 8 idles between frames.
REQ-037 Assert rst_i during the 2nd data byte -> link_o=BC(k) and tready=0 asynchronously; after release the next word produces a complete frame and counters restart at 0.
REQ-038 enable_i=0 with 2 words offered -> both consumed, drop_count_o=2, no frames; drop enable_i during a frame -> that frame completes intact.
REQ-039 Preload 0xFFFF frames -> the next frame gives frame_count_o=0x0000.
